alu_issue: RTL



---
 rtl/alu_issue_pkg.sv | 31 +++
 rtl/alu.sv | 32 +++
 rtl/alu_issue_decode.sv | 39 +++
 rtl/alu_issue.sv | 113 +++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue slice: alu_op values, funct codes,
// ALU control codes and the default datapath width.
package alu_issue_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int OP_COUNT_W = 16;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111,
        CTRL_NOR = 4'b1100
    } alu_ctrl_e;

    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND, OR, ADD, SUB, signed SLT, NOR, with a zero flag.
module alu #(
    parameter int WORD_SIZE = alu_issue_pkg::WORD_SIZE
) (
    input  logic [3:0]           alu_control,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic [WORD_SIZE-1:0] result,
    output logic                 zero
);
    import alu_issue_pkg::*;

    logic w_lt;

    assign w_lt = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (alu_control)
            CTRL_AND: result = a & b;
            CTRL_OR:  result = a | b;
            CTRL_ADD: result = a + b;
            CTRL_SUB: result = a - b;
            CTRL_SLT: result = {{(WORD_SIZE-1){1'b0}}, w_lt};
            CTRL_NOR: result = ~(a | b);
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_issue_decode.sv
// Combinational decode of (alu_op, funct) into a 4-bit ALU control code
// plus an illegal-operation flag.
module alu_decode (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       illegal
);
    import alu_issue_pkg::*;

    // Illegal encodings fall through with control 0000 so the ALU sees a benign op.
    always_comb begin
        alu_control = CTRL_AND;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = CTRL_ADD;
            ALUOP_SUB: alu_control = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_AND: alu_control = CTRL_AND;
                    FUNCT_OR:  alu_control = CTRL_OR;
                    FUNCT_ADD: alu_control = CTRL_ADD;
                    FUNCT_SUB: alu_control = CTRL_SUB;
                    FUNCT_SLT: alu_control = CTRL_SLT;
                    FUNCT_NOR: alu_control = CTRL_NOR;
                    default: begin
                        alu_control = CTRL_AND;
                        illegal     = 1'b1;
                    end
                endcase
            end
            default: begin
                alu_control = CTRL_AND;
                illegal     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue pipeline around an external combinational ALU: S1 holds the
// decoded instruction and drives the ALU, S2 captures the ALU outputs.
module alu_issue #(
    parameter int WORD_SIZE = alu_issue_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           alu_op,
    input  logic [5:0]           funct,
    input  logic [WORD_SIZE-1:0] in_a,
    input  logic [WORD_SIZE-1:0] in_b,
    output logic [3:0]           alu_control,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic                 alu_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_result,
    output logic                 out_zero,
    output logic                 out_illegal,
    output logic [15:0]          op_count
);
    import alu_issue_pkg::*;

    logic [3:0]            w_dec_ctrl;
    logic                  w_dec_illegal;
    logic                  w_s2_load;
    logic                  w_in_fire;
    logic                  w_out_fire;

    logic                  r_s1_vld;
    logic [3:0]            r_s1_ctrl;
    logic                  r_s1_illegal;
    logic [WORD_SIZE-1:0]  r_s1_a;
    logic [WORD_SIZE-1:0]  r_s1_b;

    logic                  r_out_valid;
    logic [WORD_SIZE-1:0]  r_out_result;
    logic                  r_out_zero;
    logic                  r_out_illegal;
    logic [OP_COUNT_W-1:0] r_op_count;

    alu_decode u_decode (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (w_dec_ctrl),
        .illegal     (w_dec_illegal)
    );

    // S1 may accept whenever it is empty or its contents move into S2 this edge.
    assign w_s2_load  = r_s1_vld && (!r_out_valid || out_ready);
    assign in_ready   = !r_s1_vld || w_s2_load;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // S1: decoded control and operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld     <= 1'b0;
            r_s1_ctrl    <= 4'b0000;
            r_s1_illegal <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
        end else if (w_in_fire) begin
            r_s1_vld     <= 1'b1;
            r_s1_ctrl    <= w_dec_ctrl;
            r_s1_illegal <= w_dec_illegal;
            r_s1_a       <= in_a;
            r_s1_b       <= in_b;
        end else if (w_s2_load) begin
            r_s1_vld     <= 1'b0;
        end
    end

    assign alu_control = r_s1_vld ? r_s1_ctrl : 4'b0000;
    assign alu_a       = r_s1_vld ? r_s1_a : '0;
    assign alu_b       = r_s1_vld ? r_s1_b : '0;

    // S2: captured ALU result, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_zero    <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= r_s1_illegal ? '0 : alu_result;
            r_out_zero    <= r_s1_illegal ? 1'b0 : alu_zero;
            r_out_illegal <= r_s1_illegal;
        end else if (w_out_fire) begin
            r_out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_out_fire) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_zero    = r_out_zero;
    assign out_illegal = r_out_illegal;
    assign op_count    = r_op_count;

endmodule
